// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding and byte/word geometry.
package boot_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CSUM_W         = 8;

  typedef enum logic [2:0] {
    StLenHi,
    StLenLo,
    StData,
    StWrite,
    StCsum,
    StDone,
    StError
  } boot_state_e;

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream valid/ready channel feeding the boot loader.
interface boot_loader_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/word_assembler.sv
// Packs accepted data bytes MSB-first into 32-bit words and keeps a running XOR of every byte.
module word_assembler
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic [31:0]       word_next,
  output logic              word_full,
  output logic [CSUM_W-1:0] csum
);

  logic [23:0]       shift_q;
  logic [1:0]        cnt_q;
  logic [CSUM_W-1:0] csum_q;

  // Combinational view of the word including the byte arriving now, so the top can
  // register it on the same edge that accepts the 4th byte.
  assign word_next = {shift_q, byte_in};
  assign word_full = byte_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign csum      = csum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
    end else if (byte_valid) begin
      shift_q <= word_next[23:0];
      cnt_q   <= cnt_q + 2'd1;
      csum_q  <= csum_q ^ byte_in;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed, XOR-checksummed image into instruction memory and releases
// the processor reset only once the whole image has been written and verified.
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  boot_loader_if.slave      in_if,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT_CYCLES - 1);

  boot_state_e       state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic              in_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              cpu_reset_q;
  logic              done_q;
  logic              error_q;
  logic [15:0]       words_loaded_q;

  logic              accept;
  logic              counting;
  logic [31:0]       word_next;
  logic              word_full;
  logic [CSUM_W-1:0] csum;

  assign accept = in_if.in_valid && in_ready_q;

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (accept && (state_q == StData)),
    .byte_in    (in_if.in_data),
    .word_next  (word_next),
    .word_full  (word_full),
    .csum       (csum)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idle_d   = '0;
    counting = state_q inside {StLenLo, StData, StCsum};

    if (counting && !accept) begin
      idle_d = idle_q + IdleW'(1);
    end

    unique case (state_q)
      StLenHi: begin
        if (accept) begin
          len_d   = {in_if.in_data, 8'h00};
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d   = {len_q[15:8], in_if.in_data};
          state_d = (len_d == 16'd0) ? StCsum : StData;
        end
      end
      StData: begin
        if (word_full) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        state_d = ((words_loaded_q + 16'd1) == len_q) ? StCsum : StData;
      end
      StCsum: begin
        if (accept) begin
          state_d = (in_if.in_data == csum) ? StDone : StError;
        end
      end
      StDone:  ;
      StError: ;
      default: state_d = StError;
    endcase

    // An accepted byte always beats the timeout in the same cycle.
    if (counting && !accept && (idle_q == IdleMax)) begin
      state_d = StError;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StLenHi;
      len_q          <= '0;
      idle_q         <= '0;
      in_ready_q     <= 1'b0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      cpu_reset_q    <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idle_q      <= idle_d;
      in_ready_q  <= state_d inside {StLenHi, StLenLo, StData, StCsum};
      imem_we_q   <= (state_d == StWrite);
      cpu_reset_q <= (state_d != StDone);
      done_q      <= (state_d == StDone);
      error_q     <= (state_d == StError);
      if (word_full) begin
        imem_wdata_q <= word_next;
      end
      if (state_q == StWrite) begin
        imem_addr_q    <= imem_addr_q + ADDR_W'(1);
        words_loaded_q <= words_loaded_q + 16'd1;
      end
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign imem_we        = imem_we_q;
  assign imem_addr      = imem_addr_q;
  assign imem_wdata     = imem_wdata_q;
  assign cpu_reset      = cpu_reset_q;
  assign done           = done_q;
  assign error          = error_q;
  assign words_loaded   = words_loaded_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized self-checking bench for boot_loader: images are built from word lists and the
// expected writes, checksum verdict and timeout outcome come from the stream rules.
module tb_boot_loader;

  localparam int unsigned TO = 32;
  localparam int unsigned AW = 16;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;
  logic [15:0]   words_loaded;

  int          checks = 0;
  int          failures = 0;
  int          writes_seen = 0;
  wr_t         exp_wr[$];
  logic [31:0] img[$];
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  boot_loader_if bus ();

  boot_loader #(
    .TIMEOUT_CYCLES (TO),
    .ADDR_W         (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_if        (bus),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the next expected (addr, word) of the image.
  always @(negedge clk) begin : mon
    wr_t w;
    if (imem_we === 1'b1) begin
      check_eq("ready_low_in_write", 64'(bus.in_ready), 64'd0);
      writes_seen++;
      mem[imem_addr[7:0]] = imem_wdata;
      if (exp_wr.size() == 0) begin
        check_eq("spurious_write_addr", 64'(imem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        w = exp_wr.pop_front();
        check_eq("write_addr", 64'(imem_addr), 64'(w.addr));
        check_eq("write_data", 64'(imem_wdata), 64'(w.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before test sequence completed");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] img_csum();
    logic [7:0] x = 8'h00;
    foreach (img[i]) x = x ^ img[i][31:24] ^ img[i][23:16] ^ img[i][15:8] ^ img[i][7:0];
    return x;
  endfunction

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    exp_wr.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_state();
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("rst_imem_we", 64'(imem_we), 64'd0);
    check_eq("rst_imem_addr", 64'(imem_addr), 64'd0);
    check_eq("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    check_eq("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_error", 64'(error), 64'd0);
    check_eq("rst_words_loaded", 64'(words_loaded), 64'd0);
  endtask

  // Idle for `gap` cycles, then offer the byte until it is taken (bounded).
  task automatic push_byte(input logic [7:0] b, input int gap);
    logic rdy;
    int   n;
    rdy          = 1'b0;
    n            = 0;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!rdy && n < 20) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) check_eq("byte_accepted", 64'(rdy), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  // Send img as a full stream ending with `csum`; outcome is judged from the image itself.
  task automatic run_image(input logic [7:0] csum, input int max_gap,
                           input int stall_pos, input int stall_len);
    int          n;
    int          ws;
    int          gap;
    int          k;
    logic [15:0] nn;
    logic [31:0] w;
    logic [7:0]  b;
    bit          ok;
    n  = img.size();
    nn = 16'(n);
    ws = writes_seen;
    ok = (csum == img_csum());
    for (int j = 0; j < 4 * n + 3; j++) begin
      if (j == 0) b = nn[15:8];
      else if (j == 1) b = nn[7:0];
      else if (j == 4 * n + 2) b = csum;
      else begin
        w = img[(j - 2) / 4];
        k = (j - 2) % 4;
        b = w[31 - 8 * k -: 8];
        if (k == 0) exp_wr.push_back({16'((j - 2) / 4), w});
      end
      gap = (j == stall_pos) ? stall_len : int'($urandom_range(max_gap, 0));
      push_byte(b, gap);
    end
    check_eq("done", 64'(done), 64'(ok));
    check_eq("error", 64'(error), 64'(!ok));
    check_eq("cpu_reset", 64'(cpu_reset), 64'(!ok));
    check_eq("words_loaded", 64'(words_loaded), 64'(n));
    check_eq("write_count", 64'(writes_seen - ws), 64'(n));
    check_eq("pending_writes", 64'(exp_wr.size()), 64'd0);
    check_eq("ready_terminal", 64'(bus.in_ready), 64'd0);
  endtask

  initial begin
    int ws;
    int n;
    logic [7:0] cs;

    do_reset();
    check_reset_state();
    @(posedge clk);
    #1;
    check_eq("ready_after_reset", 64'(bus.in_ready), 64'd1);

    // Reference image with held valid.
    img = '{32'h12345678, 32'h9ABCDEF0};
    run_image(8'h00, 0, -1, 0);

    // Bad checksum.
    do_reset();
    img = '{32'h000000FF};
    run_image(8'h00, 0, -1, 0);

    // Empty image.
    do_reset();
    img.delete();
    run_image(8'h00, 0, -1, 0);

    // Timeout after two data bytes: still fine after TO-1 idle cycles, error after TO.
    do_reset();
    ws = writes_seen;
    push_byte(8'h00, 0);
    push_byte(8'h01, 0);
    push_byte(8'h11, 0);
    push_byte(8'h22, 0);
    repeat (TO - 1) begin
      @(posedge clk);
      #1;
    end
    check_eq("no_error_before_timeout", 64'(error), 64'd0);
    @(posedge clk);
    #1;
    check_eq("timeout_error", 64'(error), 64'd1);
    check_eq("timeout_cpu_reset", 64'(cpu_reset), 64'd1);
    check_eq("timeout_done", 64'(done), 64'd0);
    check_eq("timeout_ready", 64'(bus.in_ready), 64'd0);
    check_eq("timeout_no_write", 64'(writes_seen - ws), 64'd0);

    // Stall of TO-1 cycles before the 3rd data byte completes normally.
    do_reset();
    img = '{$urandom()};
    run_image(img_csum(), 0, 4, TO - 1);

    // Reset asserted while the second word of a 3-word load is being written.
    do_reset();
    img = '{$urandom(), $urandom(), $urandom()};
    push_byte(8'h00, 0);
    push_byte(8'h03, 0);
    for (int j = 0; j < 8; j++) begin
      if (j % 4 == 0) exp_wr.push_back({16'(j / 4), img[j / 4]});
      push_byte(img[j / 4][31 - 8 * (j % 4) -: 8], 0);
    end
    check_eq("write_cycle_we", 64'(imem_we), 64'd1);
    check_eq("write_cycle_addr", 64'(imem_addr), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state();
    check_eq("pending_before_reset", 64'(exp_wr.size()), 64'd0);
    @(posedge clk);
    #1;
    check_eq("ready_after_midload_reset", 64'(bus.in_ready), 64'd1);
    img = '{$urandom()};
    run_image(img_csum(), 0, -1, 0);

    // 16-word image with random gaps; memory contents must match.
    do_reset();
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back($urandom());
    run_image(img_csum(), 4, -1, 0);
    for (int i = 0; i < 16; i++) check_eq("mem_content", 64'(mem[i]), 64'(img[i]));

    // Random short images, roughly half with a corrupted checksum.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      img.delete();
      n = int'($urandom_range(6, 1));
      for (int i = 0; i < n; i++) img.push_back($urandom());
      cs = img_csum();
      if ($urandom_range(1, 0) == 1) cs = cs ^ 8'($urandom_range(255, 1));
      run_image(cs, 3, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
